// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: ALU results win, multdiv results queue behind them.
// Define WB_BYPASS_EN to enable the read-port bypass outputs (tied to 0 otherwise).
module writeback_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        ctrl_reset_n,
    input  logic        alu_wb_valid,
    input  logic [4:0]  alu_wb_reg,
    input  logic [31:0] alu_wb_data,
    input  logic        md_valid,
    input  logic [4:0]  md_reg,
    input  logic [31:0] md_data,
    output logic        md_ready,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg,
    input  logic [4:0]  ctrl_readRegA,
    input  logic [4:0]  ctrl_readRegB,
    output logic        fwd_hitA,
    output logic        fwd_hitB,
    output logic [31:0] fwd_dataA,
    output logic [31:0] fwd_dataB
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    r_q_reg  [DEPTH];
    logic [31:0]   r_q_data [DEPTH];
    logic [DEPTH-1:0] r_q_sq;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_we;
    logic [4:0]    r_wreg;
    logic [31:0]   r_wdata;

    logic          w_md_live;
    logic          w_alu_take;
    logic          w_empty;
    logic          w_pop;
    logic          w_bypass;
    logic          w_push;
    logic          w_we_nxt;
    logic [4:0]    w_wreg_nxt;
    logic [31:0]   w_wdata_nxt;

    assign md_ready   = (r_count < CW'(DEPTH));
    assign w_md_live  = md_valid & md_ready & (md_reg != 5'd0);
    assign w_alu_take = alu_wb_valid & (alu_wb_reg != 5'd0);
    assign w_empty    = (r_count == CW'(0));
    assign w_pop      = ~w_alu_take & ~w_empty;
    // An md result arriving to an idle arbiter goes straight to the output stage.
    assign w_bypass   = ~w_alu_take & w_empty & w_md_live;
    assign w_push     = w_md_live & ~w_bypass;

    // Select the write for the output stage: ALU, then queue head, then direct md.
    always_comb begin
        w_we_nxt    = 1'b0;
        w_wreg_nxt  = 5'd0;
        w_wdata_nxt = 32'd0;
        if (w_alu_take) begin
            w_we_nxt    = 1'b1;
            w_wreg_nxt  = alu_wb_reg;
            w_wdata_nxt = alu_wb_data;
        end else if (w_pop) begin
            if (!r_q_sq[r_rd_ptr]) begin
                w_we_nxt    = 1'b1;
                w_wreg_nxt  = r_q_reg[r_rd_ptr];
                w_wdata_nxt = r_q_data[r_rd_ptr];
            end else begin
                w_we_nxt    = 1'b0;
            end
        end else if (w_bypass) begin
            w_we_nxt    = 1'b1;
            w_wreg_nxt  = md_reg;
            w_wdata_nxt = md_data;
        end else begin
            w_we_nxt    = 1'b0;
        end
    end

    // Registered write port.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_we    <= 1'b0;
            r_wreg  <= 5'd0;
            r_wdata <= 32'd0;
        end else begin
            r_we    <= w_we_nxt;
            r_wreg  <= w_wreg_nxt;
            r_wdata <= w_wdata_nxt;
        end
    end

    // Queue storage; the squash loop runs before the push so a same-cycle md entry stays live.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q_reg[i]  <= 5'd0;
                r_q_data[i] <= 32'd0;
            end
            r_q_sq <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_alu_take && (r_q_reg[i] == alu_wb_reg)) begin
                    r_q_sq[i] <= 1'b1;
                end
            end
            if (w_push) begin
                r_q_reg[r_wr_ptr]  <= md_reg;
                r_q_data[r_wr_ptr] <= md_data;
                r_q_sq[r_wr_ptr]   <= 1'b0;
            end
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign ctrl_writeEnable = r_we;
    assign ctrl_writeReg    = r_wreg;
    assign data_writeReg    = r_wdata;

`ifdef WB_BYPASS_EN
    assign fwd_hitA  = r_we & (ctrl_readRegA == r_wreg);
    assign fwd_hitB  = r_we & (ctrl_readRegB == r_wreg);
    assign fwd_dataA = fwd_hitA ? r_wdata : 32'd0;
    assign fwd_dataB = fwd_hitB ? r_wdata : 32'd0;
`else
    logic w_unused_rd;
    assign w_unused_rd = ^{ctrl_readRegA, ctrl_readRegB};
    assign fwd_hitA  = 1'b0;
    assign fwd_hitB  = 1'b0;
    assign fwd_dataA = 32'd0;
    assign fwd_dataB = 32'd0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed table-driven bench for writeback_arbiter plus hand-written reset sequences.
module tb_writeback_arbiter;

    logic        clock = 1'b0;
    logic        ctrl_reset_n = 1'b1;
    logic        alu_wb_valid = 1'b0;
    logic [4:0]  alu_wb_reg = 5'd0;
    logic [31:0] alu_wb_data = 32'd0;
    logic        md_valid = 1'b0;
    logic [4:0]  md_reg = 5'd0;
    logic [31:0] md_data = 32'd0;
    logic        md_ready;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [4:0]  ctrl_readRegA = 5'd0;
    logic [4:0]  ctrl_readRegB = 5'd0;
    logic        fwd_hitA, fwd_hitB;
    logic [31:0] fwd_dataA, fwd_dataB;

    int n_cmp = 0;
    int n_fail = 0;

    writeback_arbiter #(.DEPTH(4)) dut (
        .clock(clock), .ctrl_reset_n(ctrl_reset_n),
        .alu_wb_valid(alu_wb_valid), .alu_wb_reg(alu_wb_reg), .alu_wb_data(alu_wb_data),
        .md_valid(md_valid), .md_reg(md_reg), .md_data(md_data), .md_ready(md_ready),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .fwd_hitA(fwd_hitA), .fwd_hitB(fwd_hitB), .fwd_dataA(fwd_dataA), .fwd_dataB(fwd_dataB)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mr;
        logic [31:0] mdat;
        logic [4:0]  rb;
        logic        rdy;
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic av, logic [4:0] ar, logic [31:0] ad,
                                logic mv, logic [4:0] mr, logic [31:0] mdat, logic [4:0] rb,
                                logic rdy, logic we, logic [4:0] wr, logic [31:0] wd);
        vec_t v;
        v.av = av; v.ar = ar; v.ad = ad; v.mv = mv; v.mr = mr; v.mdat = mdat; v.rb = rb;
        v.rdy = rdy; v.we = we; v.wr = wr; v.wd = wd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mr, input logic [31:0] mdat);
        alu_wb_valid = av; alu_wb_reg = ar; alu_wb_data = ad;
        md_valid = mv; md_reg = mr; md_data = mdat;
    endtask

    task automatic chk_port(input string tag, input logic we, input logic [4:0] wr,
                            input logic [31:0] wd);
        chk({tag, ".we"},   {31'd0, ctrl_writeEnable}, {31'd0, we});
        chk({tag, ".wreg"}, {27'd0, ctrl_writeReg},    {27'd0, wr});
        chk({tag, ".wdat"}, data_writeReg,             wd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic        exp_hit;
        logic [31:0] exp_fd;

        // md r5=0x11 pending, x = unused regs
        tbl.push_back(mk(1'b0,5'd0,32'h0,     1'b1,5'd5,32'h11,  5'd5,  1'b1, 1'b1,5'd5,32'h11));
        tbl.push_back(mk(1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,   5'd0,  1'b1, 1'b0,5'd0,32'h0));
        // ALU r3 for six cycles while md r4..r9 offered
        tbl.push_back(mk(1'b1,5'd3,32'hA,     1'b1,5'd4,32'h44,  5'd0,  1'b1, 1'b1,5'd3,32'hA));
        tbl.push_back(mk(1'b1,5'd3,32'hA,     1'b1,5'd5,32'h45,  5'd0,  1'b1, 1'b1,5'd3,32'hA));
        tbl.push_back(mk(1'b1,5'd3,32'hA,     1'b1,5'd6,32'h46,  5'd0,  1'b1, 1'b1,5'd3,32'hA));
        tbl.push_back(mk(1'b1,5'd3,32'hA,     1'b1,5'd7,32'h47,  5'd0,  1'b1, 1'b1,5'd3,32'hA));
        tbl.push_back(mk(1'b1,5'd3,32'hA,     1'b1,5'd8,32'h48,  5'd0,  1'b0, 1'b1,5'd3,32'hA));
        tbl.push_back(mk(1'b1,5'd3,32'hA,     1'b1,5'd8,32'h48,  5'd0,  1'b0, 1'b1,5'd3,32'hA));
        tbl.push_back(mk(1'b0,5'd0,32'h0,     1'b1,5'd8,32'h48,  5'd0,  1'b0, 1'b1,5'd4,32'h44));
        tbl.push_back(mk(1'b0,5'd0,32'h0,     1'b1,5'd8,32'h48,  5'd0,  1'b1, 1'b1,5'd5,32'h45));
        tbl.push_back(mk(1'b0,5'd0,32'h0,     1'b1,5'd9,32'h49,  5'd0,  1'b1, 1'b1,5'd6,32'h46));
        tbl.push_back(mk(1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,   5'd0,  1'b1, 1'b1,5'd7,32'h47));
        tbl.push_back(mk(1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,   5'd0,  1'b1, 1'b1,5'd8,32'h48));
        tbl.push_back(mk(1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,   5'd0,  1'b1, 1'b1,5'd9,32'h49));
        tbl.push_back(mk(1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,   5'd0,  1'b1, 1'b0,5'd0,32'h0));
        // queued md r7 squashed by younger ALU r7
        tbl.push_back(mk(1'b1,5'd1,32'h55,    1'b1,5'd7,32'h1,   5'd7,  1'b1, 1'b1,5'd1,32'h55));
        tbl.push_back(mk(1'b1,5'd7,32'h2,     1'b0,5'd0,32'h0,   5'd7,  1'b1, 1'b1,5'd7,32'h2));
        tbl.push_back(mk(1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,   5'd7,  1'b1, 1'b0,5'd0,32'h0));
        tbl.push_back(mk(1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,   5'd7,  1'b1, 1'b0,5'd0,32'h0));
        // same-cycle ALU and md to r8: md is younger
        tbl.push_back(mk(1'b1,5'd8,32'h3,     1'b1,5'd8,32'h4,   5'd8,  1'b1, 1'b1,5'd8,32'h3));
        tbl.push_back(mk(1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,   5'd8,  1'b1, 1'b1,5'd8,32'h4));
        tbl.push_back(mk(1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,   5'd8,  1'b1, 1'b0,5'd0,32'h0));
        // r0 results are discarded
        tbl.push_back(mk(1'b1,5'd0,32'hFF,    1'b1,5'd0,32'hEE,  5'd0,  1'b1, 1'b0,5'd0,32'h0));
        tbl.push_back(mk(1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,   5'd0,  1'b1, 1'b0,5'd0,32'h0));
        // bypass probe
        tbl.push_back(mk(1'b1,5'd12,32'hCAFE, 1'b0,5'd0,32'h0,   5'd12, 1'b1, 1'b1,5'd12,32'hCAFE));
        // FIFO order with a squashed middle entry
        tbl.push_back(mk(1'b1,5'd1,32'h10,    1'b1,5'd2,32'h20,  5'd3,  1'b1, 1'b1,5'd1,32'h10));
        tbl.push_back(mk(1'b1,5'd1,32'h11,    1'b1,5'd3,32'h30,  5'd3,  1'b1, 1'b1,5'd1,32'h11));
        tbl.push_back(mk(1'b1,5'd2,32'h22,    1'b1,5'd4,32'h40,  5'd3,  1'b1, 1'b1,5'd2,32'h22));
        tbl.push_back(mk(1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,   5'd3,  1'b1, 1'b0,5'd0,32'h0));
        tbl.push_back(mk(1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,   5'd3,  1'b1, 1'b1,5'd3,32'h30));
        tbl.push_back(mk(1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,   5'd3,  1'b1, 1'b1,5'd4,32'h40));
        tbl.push_back(mk(1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,   5'd3,  1'b1, 1'b0,5'd0,32'h0));

        // Reset with md r5 offered: nothing may be accepted or written.
        #1 ctrl_reset_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h11);
        #1;
        chk("rst.ready", {31'd0, md_ready}, 32'd1);
        chk_port("rst.early", 1'b0, 5'd0, 32'h0);
        repeat (2) @(posedge clock);
        #1;
        chk("rst.ready_edge", {31'd0, md_ready}, 32'd1);
        chk_port("rst.edge", 1'b0, 5'd0, 32'h0);
        #1 ctrl_reset_n = 1'b1;
        #1 chk_port("rel", 1'b0, 5'd0, 32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clock);
            drive(tbl[i].av, tbl[i].ar, tbl[i].ad, tbl[i].mv, tbl[i].mr, tbl[i].mdat);
            ctrl_readRegA = tbl[i].rb;
            ctrl_readRegB = tbl[i].rb;
            #1 chk($sformatf("v%0d.ready", i), {31'd0, md_ready}, {31'd0, tbl[i].rdy});
            @(posedge clock);
            #1;
            chk_port($sformatf("v%0d", i), tbl[i].we, tbl[i].wr, tbl[i].wd);
`ifdef WB_BYPASS_EN
            exp_hit = tbl[i].we && (tbl[i].rb == tbl[i].wr);
`else
            exp_hit = 1'b0;
`endif
            exp_fd = exp_hit ? tbl[i].wd : 32'h0;
            chk($sformatf("v%0d.hitA", i), {31'd0, fwd_hitA}, {31'd0, exp_hit});
            chk($sformatf("v%0d.hitB", i), {31'd0, fwd_hitB}, {31'd0, exp_hit});
            chk($sformatf("v%0d.fdatA", i), fwd_dataA, exp_fd);
            chk($sformatf("v%0d.fdatB", i), fwd_dataB, exp_fd);
        end

        // Mid-operation reset: two md entries queued and a write pending.
        @(negedge clock);
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
        @(negedge clock);
        drive(1'b1, 5'd1, 32'h3, 1'b1, 5'd3, 32'h3);
        @(posedge clock);
        #1 chk_port("mid.pre", 1'b1, 5'd1, 32'h3);
        #1 ctrl_reset_n = 1'b0;
        #1;
        chk_port("mid.async", 1'b0, 5'd0, 32'h0);
        chk("mid.ready", {31'd0, md_ready}, 32'd1);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h66);
        @(posedge clock);
        #1 chk_port("mid.hold", 1'b0, 5'd0, 32'h0);
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        #1 chk_port("mid.rel", 1'b0, 5'd0, 32'h0);
        @(posedge clock);
        #1 chk_port("mid.first", 1'b1, 5'd6, 32'h66);
        @(negedge clock);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1 chk_port($sformatf("mid.drain%0d", k), 1'b0, 5'd0, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
